latch_bank_wr: RTL

Write controller for a bank of level-sensitive transparent latches. It accepts write requests on a valid/ready interface and turns each one into a timed enable sequence: data setup, enable open, data hold. The result is a latch write that is glitch-free and meets setup and hold at the latch. It sits between the register-programming logic and a latch-based storage bank (`latch_bank`), and is the writer for that bank's latches.

---
 rtl/latch_bank_wr_pkg.sv | 9 +
 rtl/latch_bank.sv | 16 +
 rtl/latch_bank_wr.sv | 92 +++++++++
 3 files changed

// File: rtl/latch_bank_wr_pkg.sv
// latch_bank_wr_pkg: state encoding and default parameters for the latch bank writer
package latch_bank_wr_pkg;
  typedef enum logic [1:0] {LBW_IDLE, LBW_SETUP, LBW_OPEN, LBW_HOLD} lbw_state_e;
  localparam int LBW_DATA_W    = 8;
  localparam int LBW_DEPTH     = 4;
  localparam int LBW_SETUP_CYC = 1;
  localparam int LBW_OPEN_CYC  = 2;
  localparam int LBW_HOLD_CYC  = 1;
endpackage

// File: rtl/latch_bank.sv
// latch_bank: DEPTH x DATA_W transparent latch storage written through per-word enables
module latch_bank #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic [DEPTH-1:0]        lat_en,
  input  logic [DATA_W-1:0]       lat_d,
  output logic [DEPTH*DATA_W-1:0] lat_q
);
  for (genvar i = 0; i < DEPTH; i++) begin : g_w
    logic [DATA_W-1:0] w;
    // word i is transparent while its enable is high
    always_latch if (lat_en[i]) w = lat_d;
    assign lat_q[i*DATA_W +: DATA_W] = w;
  end
endmodule

// File: rtl/latch_bank_wr.sv
// latch_bank_wr: setup/open/hold write sequencer for a latch bank; LATCH_BANK_WR_VERIFY_EN adds readback check
module latch_bank_wr
  import latch_bank_wr_pkg::*;
#(
  parameter int DATA_W    = LBW_DATA_W,
  parameter int DEPTH     = LBW_DEPTH,
  parameter int SETUP_CYC = LBW_SETUP_CYC,
  parameter int OPEN_CYC  = LBW_OPEN_CYC,
  parameter int HOLD_CYC  = LBW_HOLD_CYC,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic [DEPTH-1:0]  lat_en,
  output logic [DATA_W-1:0] lat_d,
  output logic              busy,
  output logic              done
`ifdef LATCH_BANK_WR_VERIFY_EN
  ,
  input  logic [DEPTH*DATA_W-1:0] lat_q,
  output logic                    err
`endif
);
  localparam int MAXC = (SETUP_CYC > OPEN_CYC ? (SETUP_CYC > HOLD_CYC ? SETUP_CYC : HOLD_CYC)
                                              : (OPEN_CYC > HOLD_CYC ? OPEN_CYC : HOLD_CYC));
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] S_LD = CW'(SETUP_CYC > 0 ? SETUP_CYC - 1 : 0);
  localparam logic [CW-1:0] O_LD = CW'(OPEN_CYC - 1);
  localparam logic [CW-1:0] H_LD = CW'(HOLD_CYC > 0 ? HOLD_CYC - 1 : 0);
  lbw_state_e        state;
  logic [CW-1:0]     cnt;
  logic [ADDR_W-1:0] addr;
  assign req_ready = !rst && state == LBW_IDLE;
  assign busy = state != LBW_IDLE;
  // phase sequencer; lat_d doubles as the captured write data and only moves on a handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= LBW_IDLE;
      cnt    <= '0;
      addr   <= '0;
      lat_en <= '0;
      lat_d  <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        LBW_IDLE:
          if (req_valid) begin
            addr  <= req_addr;
            lat_d <= req_data;
            if (SETUP_CYC > 0) begin
              state <= LBW_SETUP;
              cnt   <= S_LD;
            end else begin
              state  <= LBW_OPEN;
              cnt    <= O_LD;
              lat_en <= DEPTH'(1) << req_addr;
            end
          end
        LBW_SETUP:
          if (cnt == '0) begin
            state  <= LBW_OPEN;
            cnt    <= O_LD;
            lat_en <= DEPTH'(1) << addr;
          end else cnt <= cnt - CW'(1);
        LBW_OPEN:
          if (cnt == '0) begin
            lat_en <= '0;
            if (HOLD_CYC > 0) begin
              state <= LBW_HOLD;
              cnt   <= H_LD;
            end else begin
              state <= LBW_IDLE;
              done  <= 1'b1;
            end
          end else cnt <= cnt - CW'(1);
        default:
          if (cnt == '0) begin
            state <= LBW_IDLE;
            done  <= 1'b1;
          end else cnt <= cnt - CW'(1);
      endcase
    end
  end
`ifdef LATCH_BANK_WR_VERIFY_EN
  assign err = done && lat_q[addr*DATA_W +: DATA_W] != lat_d;
`endif
endmodule
